// File: rtl/arbiter_rr_n.sv
// N-requester round-robin arbiter with registered one-hot grant, binary grant index and bounded hold.
// Define ARBITER_RR_N_SVA_EN to compile the embedded protocol assertions and per-index grant covers.
module arbiter_rr_n #(
   parameter  int unsigned N        = 4,
   parameter  int unsigned MAX_HOLD = 8,
   localparam int unsigned IDW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           busy,
   output logic           pr_state
);

   localparam int unsigned HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam bit          ROT_EN   = (MAX_HOLD > 0);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic           busy_q, busy_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [HW-1:0]  hcnt_q, hcnt_d;

   logic [N-1:0]   others;
   logic [N-1:0]   pick_v;
   logic [IDW-1:0] win;
   logic           own_req;
   logic           at_limit;
   logic           new_grant;

   // First set bit of v scanning from p upward with wrap modulo N.
   function automatic logic [IDW-1:0] pick(input logic [N-1:0] v, input logic [IDW-1:0] p);
      logic [IDW-1:0] r;
      logic           found;
      int unsigned    t;
      r     = '0;
      found = 1'b0;
      for (int unsigned o = 0; o < N; o++) begin
         t = 32'(p) + o;
         if (t >= N) t = t - N;
         if (!found && v[IDW'(t)]) begin
            r     = IDW'(t);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      busy_d    = busy_q;
      ptr_d     = ptr_q;
      hcnt_d    = hcnt_q;
      new_grant = 1'b0;
      pick_v    = '0;

      others   = req & ~gnt_q;
      own_req  = |(req & gnt_q);
      at_limit = ROT_EN && ((32'(hcnt_q) + 32'd1) >= MAX_HOLD);

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               new_grant = 1'b1;
               pick_v    = req;
            end
         end
         ST_GRANT: begin
            if (own_req && !(at_limit && (|others))) begin
               if (hcnt_q != HOLD_MAX) hcnt_d = hcnt_q + HW'(1);
            end else if (|others) begin
               new_grant = 1'b1;
               pick_v    = others;
            end else begin
               state_d  = ST_IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
               hcnt_d   = '0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
            hcnt_d   = '0;
         end
      endcase

      win = pick(pick_v, ptr_q);
      // Every new grant (from IDLE or handover) restarts hold count and moves priority past the winner.
      if (new_grant) begin
         state_d  = ST_GRANT;
         gnt_d    = N'(1) << win;
         gnt_id_d = win;
         busy_d   = 1'b1;
         hcnt_d   = '0;
         ptr_d    = (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
         ptr_q    <= '0;
         hcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
         hcnt_q   <= hcnt_d;
      end
   end

   assign gnt      = gnt_q;
   assign gnt_id   = gnt_id_q;
   assign busy     = busy_q;
   assign pr_state = state_q;

`ifdef ARBITER_RR_N_SVA_EN
   a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));

   a_idle_zero : assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_IDLE) |-> (gnt_q == '0));

   a_idle_start : assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_IDLE && (|req)) |=> (state_q == ST_GRANT));

   a_grant_req : assert property (@(posedge clk) disable iff (rst)
      ((gnt_d & ~req) == '0));

   a_no_bubble : assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_GRANT && !(|(req & gnt_q)) && (|(req & ~gnt_q))) |=> (state_q == ST_GRANT));

   if (MAX_HOLD > 0) begin : g_hold_sva
      a_max_hold : assert property (@(posedge clk) disable iff (rst)
         (state_q == ST_GRANT && at_limit && (|(req & ~gnt_q))) |=> (hcnt_q == '0));
   end

   for (genvar i = 0; i < N; i++) begin : g_cov
      c_gnt : cover property (@(posedge clk) disable iff (rst) gnt_q[i]);
   end
`endif

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Directed scoreboard bench for arbiter_rr_n with N=4, MAX_HOLD=4.
module tb_arbiter_rr_n;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       pr_state;

   int n_asserts = 0;
   int n_fail    = 0;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] id;
      logic       busy;
      logic       st;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];

   arbiter_rr_n #(.N(4), .MAX_HOLD(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .gnt      (gnt),
      .gnt_id   (gnt_id),
      .busy     (busy),
      .pr_state (pr_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [1:0] enc(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] eg, input string tag);
      exp_t e;
      e.gnt  = eg;
      e.id   = enc(eg);
      e.busy = |eg;
      e.st   = |eg;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic pop_compare();
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".gnt"},      32'(gnt),      32'(e.gnt));
      check({t, ".gnt_id"},   32'(gnt_id),   32'(e.id));
      check({t, ".busy"},     32'(busy),     32'(e.busy));
      check({t, ".pr_state"}, 32'(pr_state), 32'(e.st));
   endtask

   // Drive req on the falling edge, compare just after the next rising edge.
   task automatic cyc(input logic [3:0] r, input logic [3:0] eg, input string tag);
      @(negedge clk);
      req = r;
      push(eg, tag);
      @(posedge clk);
      #1;
      pop_compare();
   endtask

   // Assert reset between edges, verify outputs clear without a clock, release on next falling edge.
   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      push(4'b0000, tag);
      pop_compare();
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0000;
   endtask

   initial begin
      rst = 1'b0;
      req = 4'b0000;
      #2 rst = 1'b1;
      #1;
      push(4'b0000, "reset");
      pop_compare();
      @(negedge clk);
      rst = 1'b0;

      // 1: first grant one clock after request
      cyc(4'b0011, 4'b0001, "t1_first");
      // 2: hold, then handover without a bubble
      cyc(4'b0011, 4'b0001, "t2_hold_a");
      cyc(4'b0011, 4'b0001, "t2_hold_b");
      cyc(4'b0010, 4'b0010, "t2_handover");
      cyc(4'b0000, 4'b0000, "t2_idle");

      // 3: forced rotation every 4 cycles from a clean pointer
      pulse_reset("t3_reset");
      for (int i = 0; i < 12; i++)
         cyc(4'b0101, ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0100, $sformatf("t3_rot%0d", i));

      // 4: owner 3 drops, pointer wraps to 0
      cyc(4'b1000, 4'b1000, "t4_own3");
      cyc(4'b1001, 4'b1000, "t4_hold3");
      cyc(4'b0001, 4'b0001, "t4_wrap");

      // 5: release to IDLE and stay there
      cyc(4'b0000, 4'b0000, "t5_idle");
      for (int i = 0; i < 3; i++) cyc(4'b0000, 4'b0000, $sformatf("t5_stay%0d", i));

      // 6: async reset mid-grant, then restart from pointer 0
      cyc(4'b0100, 4'b0100, "t6_own2");
      pulse_reset("t6_reset");
      cyc(4'b1000, 4'b1000, "t6_after");
      cyc(4'b0011, 4'b0001, "t6_ptr0");

      // pointer must be cleared by reset (pre-reset pointer would be 2)
      cyc(4'b0010, 4'b0010, "t7_own1");
      pulse_reset("t7_reset");
      cyc(4'b0101, 4'b0001, "t7_ptr_clr");

      // lone owner past the hold limit keeps its grant
      for (int i = 0; i < 6; i++) cyc(4'b0001, 4'b0001, $sformatf("t8_alone%0d", i));
      cyc(4'b0000, 4'b0000, "t8_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
